// File: rtl/vga_pkg.sv
`timescale 1ns/1ps
// Display geometry shared by the sprite controllers.
package vga_pkg;
  localparam int HOR_PIXELS = 800;
  localparam int VER_PIXELS = 600;
endpackage

// File: rtl/player_multishot_ctl.sv
`timescale 1ns/1ps
// Player ship controller: tick-paced movement, a pool of bullet slots with fire
// cooldown, and a PLAY/HIT/DEAD life state machine.
module player_multishot_ctl
  import vga_pkg::*;
#(
  parameter int PLAYER_WIDTH   = 32,
  parameter int PLAYER_HEIGHT  = 32,
  parameter int BULLET_WIDTH   = 32,
  parameter int BULLET_HEIGHT  = 32,
  parameter int MOVEMENT_SPEED = 5,
  parameter int BULLET_SPEED   = 3,
  parameter int MAX_BULLETS    = 3,
  parameter int FIRE_COOLDOWN  = 10,
  parameter int START_LIVES    = 3,
  parameter int INVULN_TICKS   = 60,
  parameter int TICK_DIV       = 650000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      button_left,
  input  logic                      button_right,
  input  logic                      button_shoot,
  input  logic [MAX_BULLETS-1:0]    bullet_hit,
  input  logic                      player_hit,
  output logic [11:0]               xpos,
  output logic [12*MAX_BULLETS-1:0] bullet_x,
  output logic [12*MAX_BULLETS-1:0] bullet_y,
  output logic [MAX_BULLETS-1:0]    bullet_active,
  output logic [2:0]                lives,
  output logic [1:0]                state
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = (FIRE_COOLDOWN > 0) ? $clog2(FIRE_COOLDOWN + 1) : 1;
  localparam int IW = (INVULN_TICKS > 0) ? $clog2(INVULN_TICKS + 1) : 1;

  localparam logic [TW-1:0]      TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [CW-1:0]      CD_LOAD    = CW'(FIRE_COOLDOWN);
  localparam logic [IW-1:0]      INV_LOAD   = IW'(INVULN_TICKS);
  localparam logic [11:0]        X_MID      = 12'(HOR_PIXELS / 2);
  localparam logic signed [13:0] X_MAX      = 14'(HOR_PIXELS - PLAYER_WIDTH);
  localparam logic signed [13:0] MOVE       = 14'(MOVEMENT_SPEED);
  localparam logic [11:0]        BX_OFF     = 12'(PLAYER_WIDTH / 2 - BULLET_WIDTH / 2);
  localparam logic [11:0]        BY_START   = 12'(VER_PIXELS - PLAYER_HEIGHT - BULLET_HEIGHT);
  localparam logic [11:0]        BY_RETIRE  = 12'(BULLET_SPEED + BULLET_HEIGHT);
  localparam logic [11:0]        BY_STEP    = 12'(BULLET_SPEED);
  localparam logic [2:0]         LIVES_INIT = 3'(START_LIVES);

  typedef enum logic [1:0] {PLAY = 2'b00, HIT = 2'b01, DEAD = 2'b10} state_e;

  function automatic logic [11:0] sat_x(input logic signed [13:0] v);
    if (v < 14'sd0) return 12'd0;
    if (v > X_MAX) return X_MAX[11:0];
    return v[11:0];
  endfunction

  function automatic logic [11:0] move_x(input logic [11:0] x, input logic left,
                                         input logic right);
    logic signed [13:0] xs;
    xs = $signed({2'b00, x});
    if (left && !right) xs = xs - MOVE;
    else if (right && !left) xs = xs + MOVE;
    return sat_x(xs);
  endfunction

  logic [TW-1:0]          tick_cnt;
  logic                   tick;
  logic                   shoot_p1, shoot_pend, phit_flag;
  logic [MAX_BULLETS-1:0] bhit_flag;
  logic                   fire_req, can_fire, slot_taken;
  logic [MAX_BULLETS-1:0] bhit_now;
  logic                   phit_now;

  logic [11:0]            xpos_q, xpos_n;
  logic [11:0]            bx_q [MAX_BULLETS];
  logic [11:0]            bx_n [MAX_BULLETS];
  logic [11:0]            by_q [MAX_BULLETS];
  logic [11:0]            by_n [MAX_BULLETS];
  logic [MAX_BULLETS-1:0] act_q, act_n;
  logic [2:0]             lives_q, lives_n;
  state_e                 st_q, st_n;
  logic [CW-1:0]          cd_q, cd_n;
  logic [IW-1:0]          inv_q, inv_n;

  // Requests arriving on the tick cycle itself are folded in directly.
  assign tick     = (tick_cnt == TICK_LAST);
  assign fire_req = shoot_pend | (button_shoot & ~shoot_p1);
  assign bhit_now = bhit_flag | bullet_hit;
  assign phit_now = phit_flag | player_hit;
  assign can_fire = (st_q == PLAY) && fire_req && (cd_q == '0);

  always_comb begin
    xpos_n     = xpos_q;
    act_n      = act_q;
    bx_n       = bx_q;
    by_n       = by_q;
    lives_n    = lives_q;
    st_n       = st_q;
    cd_n       = cd_q;
    inv_n      = inv_q;
    slot_taken = 1'b0;

    for (int i = 0; i < MAX_BULLETS; i++) begin
      if (act_q[i]) begin
        if (bhit_now[i] || (by_q[i] < BY_RETIRE)) act_n[i] = 1'b0;
        else by_n[i] = by_q[i] - BY_STEP;
      end else if (can_fire && !slot_taken) begin
        slot_taken = 1'b1;
        act_n[i]   = 1'b1;
        bx_n[i]    = xpos_q + BX_OFF;
        by_n[i]    = BY_START;
      end
    end

    if (slot_taken) cd_n = CD_LOAD;
    else if (cd_q != '0) cd_n = cd_q - CW'(1);

    case (st_q)
      PLAY: begin
        xpos_n = move_x(xpos_q, button_left, button_right);
        if (phit_now) begin
          lives_n = lives_q - 3'd1;
          if (lives_q == 3'd1) begin
            st_n = DEAD;
          end else begin
            st_n  = HIT;
            inv_n = INV_LOAD;
          end
        end
      end
      HIT: begin
        if (inv_q <= IW'(1)) begin
          inv_n  = '0;
          st_n   = PLAY;
          xpos_n = X_MID;
        end else begin
          inv_n = inv_q - IW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt   <= '0;
      shoot_p1   <= 1'b0;
      shoot_pend <= 1'b0;
      bhit_flag  <= '0;
      phit_flag  <= 1'b0;
      xpos_q     <= X_MID;
      act_q      <= '0;
      lives_q    <= LIVES_INIT;
      st_q       <= PLAY;
      cd_q       <= '0;
      inv_q      <= '0;
      for (int i = 0; i < MAX_BULLETS; i++) begin
        bx_q[i] <= '0;
        by_q[i] <= '0;
      end
    end else begin
      shoot_p1 <= button_shoot;
      if (tick) begin
        tick_cnt   <= '0;
        shoot_pend <= 1'b0;
        bhit_flag  <= '0;
        phit_flag  <= 1'b0;
        xpos_q     <= xpos_n;
        act_q      <= act_n;
        lives_q    <= lives_n;
        st_q       <= st_n;
        cd_q       <= cd_n;
        inv_q      <= inv_n;
        for (int i = 0; i < MAX_BULLETS; i++) begin
          bx_q[i] <= bx_n[i];
          by_q[i] <= by_n[i];
        end
      end else begin
        tick_cnt   <= tick_cnt + TW'(1);
        shoot_pend <= shoot_pend | (button_shoot & ~shoot_p1);
        bhit_flag  <= bhit_flag | bullet_hit;
        phit_flag  <= phit_flag | player_hit;
      end
    end
  end

  for (genvar g = 0; g < MAX_BULLETS; g++) begin : g_pack
    assign bullet_x[12*g +: 12] = bx_q[g];
    assign bullet_y[12*g +: 12] = by_q[g];
  end

  assign xpos          = xpos_q;
  assign bullet_active = act_q;
  assign lives         = lives_q;
  assign state         = st_q;

endmodule

// File: doc/player_multishot_ctl.md
PLAYER_MULTISHOT_CTL -- requirements
Module: player_multishot_ctl

Interface
REQ-001 SHALL have parameter PLAYER_WIDTH, default 32: player sprite width in pixels.
REQ-002 SHALL have parameter PLAYER_HEIGHT, default 32: player sprite height in pixels.
REQ-003 SHALL have parameter BULLET_WIDTH, default 32, and BULLET_HEIGHT, default 32: bullet sprite size in pixels.
REQ-004 SHALL have parameter MOVEMENT_SPEED, default 5: pixels moved per tick.
REQ-005 SHALL have parameter BULLET_SPEED, default 3: pixels a bullet rises per tick.
REQ-006 SHALL have parameter MAX_BULLETS, default 3, legal range 1..8: number of bullet slots.
REQ-007 SHALL have parameter FIRE_COOLDOWN, default 10: minimum ticks between shots.
REQ-008 SHALL have parameter START_LIVES, default 3, legal range 1..7: lives after reset.
REQ-009 SHALL have parameter INVULN_TICKS, default 60: length of the HIT state in ticks.
REQ-010 SHALL have parameter TICK_DIV, default 650000: clk cycles per game tick.
REQ-011 SHALL take HOR_PIXELS and VER_PIXELS from vga_pkg.
REQ-012 Ports SHALL be:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- button_left  in  1  move left
- button_right  in  1  move right
- button_shoot  in  1  fire request (level)
- bullet_hit  in  MAX_BULLETS  per-slot hit pulse, any cycle
- player_hit  in  1  player struck, pulse, any cycle
- xpos  out  12  player left x
- bullet_x  out  12*MAX_BULLETS  slot i at bits [12i+11:12i]
- bullet_y  out  12*MAX_BULLETS  same packing
- bullet_active  out  MAX_BULLETS  slot in flight
- lives  out  3  remaining lives
- state  out  2  00 PLAY, 01 HIT, 10 DEAD

Function
REQ-013 SHALL run a counter 0..TICK_DIV-1; the tick is a one-cycle pulse when the counter equals TICK_DIV-1, and all game state SHALL update only on the tick.
REQ-014 SHALL capture a rising edge of button_shoot on any clk cycle into a pending flag; the flag SHALL be cleared on every tick, whether or not a shot fires.
REQ-015 SHALL hold each bullet_hit[i] pulse in a sticky flag until the next tick, then clear it; player_hit SHALL be held likewise.
REQ-016 Movement (PLAY only):
- left-only: xpos = max(xpos - MOVEMENT_SPEED, 0)
- right-only: xpos = min(xpos + MOVEMENT_SPEED, HOR_PIXELS - PLAYER_WIDTH)
- both buttons or neither: no change
REQ-017 Per tick, each active slot SHALL deactivate if its hit flag is set or bullet_y < BULLET_SPEED + BULLET_HEIGHT; otherwise bullet_y SHALL decrease by BULLET_SPEED.
REQ-018 Firing (PLAY only): when the pending flag is set, the cooldown is 0, and at least one slot is free at the start of the tick, the lowest-index free slot SHALL load:
- bullet_x = pre-move xpos + PLAYER_WIDTH/2 - BULLET_WIDTH/2
- bullet_y = VER_PIXELS - PLAYER_HEIGHT - BULLET_HEIGHT
- active = 1
- cooldown = FIRE_COOLDOWN
A newly fired bullet SHALL NOT move on its firing tick.
REQ-019 A slot freed on tick T SHALL be reusable at the earliest on tick T+1.
REQ-020 The cooldown SHALL decrement by 1 per tick while nonzero, in every state.
REQ-021 FSM transitions:
- PLAY and player flag at tick: lives decrements; if the new value is 0, go to DEAD, else go to HIT with the invulnerability counter set to INVULN_TICKS.
- HIT: player_hit is ignored (its flag is discarded); no movement or firing; the counter decrements each tick; at 0, go to PLAY and set xpos = HOR_PIXELS/2.
- DEAD: absorbing until rst; no movement or firing.
REQ-022 In-flight bullets SHALL keep moving and retiring in every state.
REQ-023 When a player hit and a fire request occur on the same tick in PLAY, the shot SHALL fire and the state transition SHALL also occur.

Reset
REQ-024 On rst the module SHALL set:
- xpos = HOR_PIXELS/2
- all bullet_x, bullet_y, bullet_active = 0
- lives = START_LIVES
- state = PLAY
- cooldown, invulnerability counter, tick counter = 0
- all pending and sticky flags = 0
REQ-025 rst SHALL take effect mid-flight, mid-HIT, and in DEAD alike, on the next clk edge.

Verification (TICK_DIV=4 for simulation)
REQ-026 Hold button_left from reset for 200 ticks -> xpos decreases 5 per tick and saturates at 0; hold button_right -> xpos saturates at HOR_PIXELS-32.
REQ-027 Three 1-cycle shoot pulses 11 ticks apart at xpos=400 -> slots 0, 1, 2 become active in order, each with bullet_x=400 and bullet_y=VER_PIXELS-64; a 4th pulse while all are in flight -> no change.
REQ-028 Two shoot pulses 5 ticks apart -> only the first fires (cooldown); a pulse at tick 10 after a shot -> rejected; a pulse at tick 11 -> fires.
REQ-029 bullet_hit[1] pulse mid-tick -> slot 1 inactive at the next tick, slots 0 and 2 unaffected; the next fire reuses slot 1.
REQ-030 Three player_hit pulses, each after HIT expires -> lives 3->2->1->0, state PLAY->HIT->PLAY->HIT->PLAY->DEAD; a player_hit during HIT -> lives unchanged.
REQ-031 rst asserted in DEAD with bullets active -> the next cycle shows all REQ-024 values.
